// File: rtl/seg_595_rx.sv
// seg_595_rx: 74HC595 refresh-stream receiver and display-image decoder; define SEG_595_RX_FRAME_CHECK_EN to reject malformed frames
module seg_595_rx #(
  parameter int SHIFT_BITS = 14
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        ds,
  input  logic        shcp,
  input  logic        stcp,
  input  logic        oe,
  output logic [7:0]  seg_code,
  output logic [5:0]  sel_code,
  output logic [23:0] digits,
  output logic [5:0]  dp_out,
  output logic        frame_vld,
  output logic        frame_err
);
  logic [1:0] ds_s, oe_s;
  logic [2:0] shcp_s, stcp_s;
  logic shcp_rise, stcp_rise, ok;
  logic [SHIFT_BITS-1:0] sr;
  logic [3:0] bit_cnt, code;
  logic [7:0] f_seg;
  logic [5:0] f_sel;
  // pin synchronisers; shcp/stcp chains reset high so reset release cannot fake an edge
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      ds_s <= '0;
      oe_s <= '0;
      shcp_s <= '1;
      stcp_s <= '1;
    end else begin
      ds_s <= {ds_s[0], ds};
      oe_s <= {oe_s[0], oe};
      shcp_s <= {shcp_s[1:0], shcp};
      stcp_s <= {stcp_s[1:0], stcp};
    end
  assign shcp_rise = shcp_s[1] & ~shcp_s[2];
  assign stcp_rise = stcp_s[1] & ~stcp_s[2];
  // shift register and saturating bit count; a coincident latch restarts the count at the new bit
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      sr <= '0;
      bit_cnt <= '0;
    end else begin
      if (shcp_rise) sr <= {sr[SHIFT_BITS-2:0], ds_s[1]};
      if (stcp_rise) bit_cnt <= {3'b000, shcp_rise};
      else if (shcp_rise && bit_cnt != 4'hF) bit_cnt <= bit_cnt + 4'd1;
    end
  // frame view of the pre-shift register and segment-pattern decode
  always_comb begin
    for (int i = 0; i < 8; i++) f_seg[i] = sr[SHIFT_BITS-1-i];
    f_sel = sr[5:0];
    case (f_seg[6:0])
      7'h40: code = 4'h0;
      7'h79: code = 4'h1;
      7'h24: code = 4'h2;
      7'h30: code = 4'h3;
      7'h19: code = 4'h4;
      7'h12: code = 4'h5;
      7'h02: code = 4'h6;
      7'h78: code = 4'h7;
      7'h00: code = 4'h8;
      7'h10: code = 4'h9;
      7'h3F: code = 4'hA;
      7'h7F: code = 4'hB;
      default: code = 4'hF;
    endcase
  end
`ifdef SEG_595_RX_FRAME_CHECK_EN
  assign ok = bit_cnt == 4'(SHIFT_BITS) && $onehot(f_sel);
`else
  assign ok = 1'b1;
`endif
  // latch accepted frames into the raw codes and the per-digit image; disabled outputs show blank
  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      seg_code <= 8'hFF;
      sel_code <= '0;
      digits <= 24'hBBBBBB;
      dp_out <= '0;
      frame_vld <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_vld <= stcp_rise & ok;
      frame_err <= stcp_rise & ~ok;
      if (stcp_rise && ok) begin
        seg_code <= f_seg;
        sel_code <= f_sel;
        for (int i = 0; i < 6; i++)
          if (f_sel[i]) begin
            digits[4*i +: 4] <= oe_s[1] ? 4'hB : code;
            dp_out[i] <= ~oe_s[1] & ~f_seg[7];
          end
      end
    end
endmodule

// File: tb/tb_seg_595_rx.sv
// tb_seg_595_rx: directed stimulus against a bit-history model of the 595 display stream
module tb_seg_595_rx;
  logic sys_clk = 0, sys_rst_n = 1, ds = 0, shcp = 1, stcp = 1, oe = 0;
  logic [7:0] seg_code;
  logic [5:0] sel_code, dp_out;
  logic [23:0] digits;
  logic frame_vld, frame_err;
  int n_chk = 0, n_fail = 0, pend = 0, nbits = 0;
  bit q[$];
  logic [7:0] m_seg = 8'hFF, p_seg;
  logic [5:0] m_sel = 0, m_dp = 0, p_sel, p_dp;
  logic [23:0] m_dig = 24'hBBBBBB, p_dig;
  logic p_ok;
  localparam logic [6:0] PAT [12] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h3F, 7'h7F};

  seg_595_rx dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe),
    .seg_code(seg_code), .sel_code(sel_code), .digits(digits), .dp_out(dp_out),
    .frame_vld(frame_vld), .frame_err(frame_err)
  );

  always #10 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] dec(input logic [6:0] s);
    for (int i = 0; i < 12; i++) if (s == PAT[i]) return 4'(i);
    return 4'hF;
  endfunction

  function automatic bit bit_at(input int age);
    return q.size() > age ? q[q.size()-1-age] : 1'b0;
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset(input int cycles);
    sys_rst_n = 0;
    q.delete();
    nbits = 0;
    pend = 0;
    m_seg = 8'hFF; m_sel = 0; m_dig = 24'hBBBBBB; m_dp = 0;
    wait_n(cycles);
    sys_rst_n = 1;
  endtask

  task automatic shift_bit(input bit b);
    ds = b;
    wait_n(2);
    shcp = 1;
    q.push_back(b);
    nbits++;
    wait_n(3);
    shcp = 0;
    wait_n(2);
  endtask

  task automatic latch();
    logic [3:0] code;
    logic dp;
    for (int i = 0; i < 8; i++) p_seg[i] = bit_at(13 - i);
    for (int j = 0; j < 6; j++) p_sel[j] = bit_at(j);
`ifdef SEG_595_RX_FRAME_CHECK_EN
    p_ok = nbits == 14 && $countones(p_sel) == 1;
`else
    p_ok = 1;
`endif
    code = oe ? 4'hB : dec(p_seg[6:0]);
    dp = oe ? 1'b0 : ~p_seg[7];
    p_dig = m_dig;
    p_dp = m_dp;
    for (int i = 0; i < 6; i++) if (p_sel[i]) begin p_dig[4*i +: 4] = code; p_dp[i] = dp; end
    nbits = 0;
    pend = 3;
    stcp = 1;
    wait_n(3);
    stcp = 0;
    wait_n(3);
  endtask

  task automatic send_frame(input logic [7:0] seg, input logic [5:0] sel, input int nb);
    for (int i = 0; i < nb; i++) shift_bit(i < 8 ? seg[i] : sel[13 - i]);
    latch();
  endtask

  always @(posedge sys_clk) begin
    logic ev, ee;
    #1;
    ev = 0;
    ee = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        if (p_ok) begin
          m_seg = p_seg; m_sel = p_sel; m_dig = p_dig; m_dp = p_dp;
          ev = 1;
        end else ee = 1;
      end
    end
    chk("frame_vld", 32'(frame_vld), 32'(ev));
    chk("frame_err", 32'(frame_err), 32'(ee));
    chk("seg_code", 32'(seg_code), 32'(m_seg));
    chk("sel_code", 32'(sel_code), 32'(m_sel));
    chk("digits", 32'(digits), 32'(m_dig));
    chk("dp_out", 32'(dp_out), 32'(m_dp));
  end

  initial begin
    #2;
    do_reset(3);
    wait_n(20);
    chk("lit_reset_digits", 32'(digits), 32'h00BBBBBB);
    chk("lit_reset_seg", 32'(seg_code), 32'hFF);
    shcp = 0;
    stcp = 0;
    wait_n(4);
    send_frame(8'hA4, 6'b000100, 14);
    chk("lit_digit2", 32'(digits), 32'h00BBB2BB);
    chk("lit_dp_a", 32'(dp_out), 32'h0);
    oe = 1;
    send_frame(8'h10, 6'b100000, 14);
    chk("lit_oe_blank", 32'(digits), 32'h00BBB2BB);
    chk("lit_oe_dp", 32'(dp_out), 32'h0);
    oe = 0;
    send_frame(8'h10, 6'b100000, 14);
    chk("lit_digit5", 32'(digits), 32'h009BB2BB);
    chk("lit_dp5", 32'(dp_out), 32'h20);
    send_frame(8'hF9, 6'b000010, 13);
`ifdef SEG_595_RX_FRAME_CHECK_EN
    chk("lit_short_frame", 32'(digits), 32'h009BB2BB);
    chk("lit_short_seg", 32'(seg_code), 32'h10);
`else
    chk("lit_short_frame", 32'(digits), 32'h00FBB2BF);
    chk("lit_short_seg", 32'(seg_code), 32'hF2);
`endif
    send_frame(8'hBF, 6'b000011, 14);
`ifdef SEG_595_RX_FRAME_CHECK_EN
    chk("lit_two_hot", 32'(digits), 32'h009BB2BB);
`else
    chk("lit_two_hot", 32'(digits), 32'h00FBB2AA);
`endif
    for (int i = 0; i < 7; i++) shift_bit(1'b1);
    do_reset(3);
    wait_n(4);
    chk("lit_midreset", 32'(digits), 32'h00BBBBBB);
    send_frame(8'hF8, 6'b000001, 14);
    chk("lit_digit0", 32'(digits), 32'h00BBBBB7);
    chk("lit_seg_f8", 32'(seg_code), 32'hF8);
    wait_n(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
